spi_master: RTL and testbench

- Host-side SPI controller for the team's SPI RAM/ROM peripheral protocol: one command byte, then a 24-bit address, both MSB-first on MOSI, then data.
- Supported commands: 03h single read, 02h single write, 63h quad read (data on d[3:0], no dummy cycles).
- Takes a transaction request from a local host interface, generates spi_clk / spi_select / data lines in SPI mode 0, and streams bytes in and out.
- Serves as the bench driver and the on-chip initiator for the peripheral.

---
 rtl/spi_master.sv | 213 +++++++++++++++++++++
 tb/tb_spi_master.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 host controller for the SPI RAM/ROM peripheral protocol.
// Sends an 8-bit command and a 24-bit address, then streams single or quad data.
module spi_master #(
    parameter int CLK_DIV  = 2,
    parameter int LEN_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [23:0]         addr,
    input  logic [LEN_BITS-1:0] len,
    output logic                busy,
    input  logic [7:0]          wr_data,
    output logic                wr_ready,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic                spi_clk,
    output logic                spi_select,
    output logic [3:0]          spi_d_out,
    output logic [3:0]          spi_d_oe,
    input  logic [3:0]          spi_d_in
);

    localparam int DW       = LEN_BITS + 3;
    localparam int TW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_LAST = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;

    localparam logic [1:0] OP_RD = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_QR = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CMD,
        DATA,
        DESEL_HI,
        DESEL_LO,
        GAP
    } state_t;

    state_t state, state_nx;

    logic [TW-1:0]       tcnt;
    logic [1:0]          op_q;
    logic [LEN_BITS-1:0] len_q;
    logic [31:0]         hdr;
    logic [4:0]          hcnt;
    logic [DW-1:0]       dcnt;
    logic [DW-1:0]       dlast;
    logic [7:0]          wbuf;
    logic [6:0]          rsh;
    logic [7:0]          rnext;

    logic tick, gap_end, shifting, rise, fall;
    logic accept, last_hdr, last_data, byte_end, wload;

    function automatic logic [7:0] cmd_of(input logic [1:0] o);
        unique case (o)
            OP_WR:   cmd_of = 8'h02;
            OP_QR:   cmd_of = 8'h63;
            default: cmd_of = 8'h03;
        endcase
    endfunction

    assign tick     = (tcnt == TW'(CLK_DIV - 1));
    assign gap_end  = (tcnt == TW'(GAP_LAST));
    assign shifting = (state == CMD) || (state == DATA);
    assign rise     = shifting && tick && !spi_clk;
    assign fall     = shifting && tick && spi_clk;
    assign accept   = start && (state == IDLE) && (op != 2'b11);
    assign last_hdr = (hcnt == 5'd31);

    assign dlast     = (op_q == OP_QR) ? {2'b00, len_q, 1'b1}
                                       : {len_q, 3'b111};
    assign last_data = (dcnt == dlast);
    assign byte_end  = (op_q == OP_QR) ? dcnt[0] : &dcnt[2:0];
    assign rnext     = (op_q == OP_QR) ? {rsh[3:0], spi_d_in}
                                       : {rsh, spi_d_in[1]};

    // Next write byte is fetched as the last bit of the current one goes out.
    assign wload = fall && (state == DATA) && (op_q == OP_WR)
                && (&dcnt[2:0]) && (dcnt[DW-1:3] < len_q);

    assign wr_ready = !rst && ((accept && op == OP_WR) || wload);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state == IDLE || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The done/idle cycle counts as the final cycle of the deselect gap.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (accept) state_nx = SELECT;
            SELECT:   if (tick) state_nx = CMD;
            CMD:      if (rise && last_hdr) state_nx = DATA;
            DATA:     if (rise && last_data) state_nx = DESEL_HI;
            DESEL_HI: if (tick) state_nx = DESEL_LO;
            DESEL_LO: if (tick) state_nx = (CLK_DIV == 1) ? IDLE : GAP;
            GAP:      if (gap_end) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            spi_clk    <= 1'b0;
            spi_select <= 1'b1;
            spi_d_out  <= '0;
            spi_d_oe   <= 4'b0001;
            op_q       <= '0;
            len_q      <= '0;
            hdr        <= '0;
            hcnt       <= '0;
            dcnt       <= '0;
            wbuf       <= '0;
            rsh        <= '0;
        end else begin
            busy     <= (state_nx != IDLE);
            done     <= (state != IDLE) && (state_nx == IDLE);
            rd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= op;
                        len_q      <= len;
                        hdr        <= {cmd_of(op), addr};
                        wbuf       <= wr_data;
                        hcnt       <= '0;
                        dcnt       <= '0;
                        spi_select <= 1'b0;
                        spi_clk    <= 1'b0;
                        spi_d_oe   <= 4'b0001;
                        spi_d_out  <= {3'b000, cmd_of(op)[7]};
                    end
                end
                CMD: begin
                    if (rise) begin
                        spi_clk <= 1'b1;
                        hcnt    <= hcnt + 5'd1;
                        if (last_hdr && op_q == OP_QR) begin
                            spi_d_oe <= 4'b0000;
                        end
                    end
                    if (fall) begin
                        spi_clk   <= 1'b0;
                        hdr       <= hdr << 1;
                        spi_d_out <= {3'b000, hdr[30]};
                    end
                end
                DATA: begin
                    if (rise) begin
                        spi_clk <= 1'b1;
                        rsh     <= rnext[6:0];
                        if (byte_end && op_q != OP_WR) begin
                            rd_valid <= 1'b1;
                            rd_data  <= rnext;
                        end
                        if (!last_data) begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    if (fall) begin
                        spi_clk <= 1'b0;
                        if (op_q == OP_WR) begin
                            spi_d_out <= {3'b000, wbuf[~dcnt[2:0]]};
                        end else begin
                            spi_d_out <= '0;
                        end
                        if (wload) begin
                            wbuf <= wr_data;
                        end
                    end
                end
                DESEL_HI: begin
                    if (tick) begin
                        spi_clk <= 1'b0;
                    end
                end
                DESEL_LO: begin
                    if (tick) begin
                        spi_select <= 1'b1;
                        spi_d_oe   <= 4'b0001;
                        spi_d_out  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI RAM/ROM peripheral.
// Two instances: CLK_DIV=2 and CLK_DIV=1, sharing one peripheral model.
module tb_spi_master;

    typedef struct {
        bit              d1;
        logic [1:0]      op;
        logic [23:0]     addr;
        logic [7:0]      len;
        logic [0:3][7:0] b;
        logic [31:0]     hdr;
        int              rises;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        use1 = 1'b0;
    logic [1:0]  op = '0;
    logic [23:0] addr = '0;
    logic [7:0]  len = '0;
    logic [7:0]  wr_data;
    logic [3:0]  s_din = '0;
    logic        st0, st1;

    logic       busy0, wrr0, rdv0, done0, sclk0, sel0;
    logic [7:0] rdd0;
    logic [3:0] do0, oe0;
    logic       busy1, wrr1, rdv1, done1, sclk1, sel1;
    logic [7:0] rdd1;
    logic [3:0] do1, oe1;

    assign st0 = start & ~use1;
    assign st1 = start & use1;

    spi_master #(.CLK_DIV(2), .LEN_BITS(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(st0), .op(op), .addr(addr),
        .len(len), .busy(busy0), .wr_data(wr_data), .wr_ready(wrr0),
        .rd_data(rdd0), .rd_valid(rdv0), .done(done0), .spi_clk(sclk0),
        .spi_select(sel0), .spi_d_out(do0), .spi_d_oe(oe0),
        .spi_d_in(s_din)
    );

    spi_master #(.CLK_DIV(1), .LEN_BITS(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .op(op), .addr(addr),
        .len(len), .busy(busy1), .wr_data(wr_data), .wr_ready(wrr1),
        .rd_data(rdd1), .rd_valid(rdv1), .done(done1), .spi_clk(sclk1),
        .spi_select(sel1), .spi_d_out(do1), .spi_d_oe(oe1),
        .spi_d_in(s_din)
    );

    logic       m_busy, m_wrr, m_rdv, m_done, m_sclk, m_sel;
    logic [7:0] m_rdd;
    logic [3:0] m_dout, m_oe;

    assign m_busy = use1 ? busy1 : busy0;
    assign m_wrr  = use1 ? wrr1  : wrr0;
    assign m_rdv  = use1 ? rdv1  : rdv0;
    assign m_done = use1 ? done1 : done0;
    assign m_sclk = use1 ? sclk1 : sclk0;
    assign m_sel  = use1 ? sel1  : sel0;
    assign m_rdd  = use1 ? rdd1  : rdd0;
    assign m_dout = use1 ? do1   : do0;
    assign m_oe   = use1 ? oe1   : oe0;

    // Peripheral: ROM contents unless the location has been written.
    logic [7:0]  mem [4096];
    bit          wr_ok [4096];
    int          s_cnt = 0;
    int          s_k;
    logic [31:0] s_hdr = '0;
    logic [7:0]  s_wb = '0;
    logic [7:0]  s_b;
    logic [11:0] s_a = '0;

    function automatic logic [7:0] rom(input logic [11:0] a);
        case (a)
            12'h000: return 8'h07;
            12'h001: return 8'h4B;
            12'h002: return 8'h08;
            12'h003: return 8'h4A;
            12'h800: return 8'hA5;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] rd_byte(input logic [11:0] a);
        return wr_ok[a] ? mem[a] : rom(a);
    endfunction

    always @(posedge m_sclk or posedge m_sel) begin
        if (m_sel) begin
            s_cnt = 0;
        end else begin
            if (s_cnt < 32) begin
                s_hdr = {s_hdr[30:0], m_dout[0]};
            end else if (s_hdr[31:24] == 8'h02) begin
                s_wb = {s_wb[6:0], m_dout[0]};
                if ((s_cnt - 32) % 8 == 7) begin
                    mem[s_a + 12'((s_cnt - 32) / 8)]   = s_wb;
                    wr_ok[s_a + 12'((s_cnt - 32) / 8)] = 1'b1;
                end
            end
            if (s_cnt == 31) s_a = s_hdr[11:0];
            s_cnt++;
        end
    end

    always @(negedge m_sclk) begin
        if (!m_sel && s_cnt >= 32) begin
            s_k = s_cnt - 32;
            if (s_hdr[31:24] == 8'h03) begin
                s_b = rd_byte(s_a + 12'(s_k / 8));
                s_din[1] = s_b[7 - (s_k % 8)];
            end else if (s_hdr[31:24] == 8'h63) begin
                s_b = rd_byte(s_a + 12'(s_k / 2));
                s_din = (s_k % 2 == 0) ? s_b[7:4] : s_b[3:0];
            end
        end
    end

    // Host side: monotonic event totals; tasks take snapshots.
    int rise_tot = 0, selr_tot = 0, rd_tot = 0, done_tot = 0, wr_tot = 0;
    int hi_run = 0, last_run = 0;
    int rise_base, selr_base, rd_base, done_base, wr_base = 0;
    logic [7:0]      rd_got [64];
    logic [0:3][7:0] wb = '0;
    logic            wr_seen;

    assign wr_data = wb[2'(wr_tot - wr_base)];

    always @(posedge m_sclk) if (!m_sel) rise_tot++;
    always @(posedge m_sel) selr_tot++;

    always @(posedge clk) begin
        wr_seen = m_wrr;
        #1;
        if (wr_seen) wr_tot++;
    end

    always @(negedge clk) begin
        if (m_rdv) begin
            rd_got[rd_tot % 64] = m_rdd;
            rd_tot++;
        end
        if (m_done) done_tot++;
        if (m_sel) begin
            hi_run++;
        end else begin
            if (hi_run > 0) last_run = hi_run;
            hi_run = 0;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        rise_base = rise_tot;
        selr_base = selr_tot;
        rd_base   = rd_tot;
        done_base = done_tot;
        wr_base   = wr_tot;
    endtask

    task automatic issue(input logic [1:0] o, input logic [23:0] a,
                         input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1; op = o; addr = a; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit poke,
                             output logic [3:0] oe31, output logic [3:0] oe32);
        int cyc;
        bit got32;
        cyc = 0;
        got32 = 0;
        oe31 = 'x;
        oe32 = 'x;
        while (done_tot == done_base && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (rise_tot - rise_base == 31) oe31 = m_oe;
            if (rise_tot - rise_base == 32 && !got32) begin
                oe32 = m_oe;
                got32 = 1;
            end
            if (poke && cyc == 30) begin
                start = 1'b1; op = 2'd2; addr = 24'h0;
            end else begin
                start = 1'b0;
            end
        end
        check({name, "_timeout"}, (cyc < 4000), 1'b1);
    endtask

    task automatic run_vec(input string name, input vec_t v, input bit poke);
        logic [3:0] oe31, oe32;
        use1 = v.d1;
        wb = v.b;
        snap();
        issue(v.op, v.addr, v.len);
        wait_done(name, poke, oe31, oe32);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_hdr"}, s_hdr, v.hdr);
        check({name, "_rises"}, rise_tot - rise_base, v.rises);
        check({name, "_done"}, done_tot - done_base, 1);
        check({name, "_selrise"}, selr_tot - selr_base, 1);
        check({name, "_busy"}, m_busy, 1'b0);
        if (v.op == 2'd1) begin
            check({name, "_nwr"}, wr_tot - wr_base, int'(v.len) + 1);
            for (int i = 0; i <= int'(v.len); i++)
                check({name, "_mem"}, rd_byte(v.addr[11:0] + 12'(i)), v.b[i]);
        end else begin
            check({name, "_nrd"}, rd_tot - rd_base, int'(v.len) + 1);
            for (int i = 0; i <= int'(v.len); i++)
                check({name, "_rd"}, rd_got[(rd_base + i) % 64], v.b[i]);
        end
        if (v.op == 2'd2) begin
            check({name, "_oe31"}, oe31, 4'b0001);
            check({name, "_oe32"}, oe32, 4'b0000);
        end
    endtask

    function automatic vec_t mk(input bit d1, input logic [1:0] o,
                                input logic [23:0] a, input logic [7:0] l,
                                input logic [31:0] b, input logic [31:0] h,
                                input int r);
        vec_t v;
        v.d1 = d1; v.op = o; v.addr = a; v.len = l;
        v.b = b; v.hdr = h; v.rises = r;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        int cyc;
        int bad;
        logic [3:0] oe31, oe32;

        vecs[0] = mk(0, 2'd0, 24'h000800, 8'd0, 32'hA5000000, 32'h03000800, 40);
        vecs[1] = mk(0, 2'd1, 24'h000801, 8'd2, 32'h11223300, 32'h02000801, 56);
        vecs[2] = mk(0, 2'd2, 24'h000000, 8'd3, 32'h074B084A, 32'h63000000, 40);
        vecs[3] = mk(1, 2'd1, 24'h000100, 8'd1, 32'hDEAD0000, 32'h02000100, 48);
        vecs[4] = mk(1, 2'd0, 24'h000100, 8'd1, 32'hDEAD0000, 32'h03000100, 48);
        vecs[5] = mk(1, 2'd2, 24'h000100, 8'd1, 32'hDEAD0000, 32'h63000100, 36);
        vecs[6] = mk(0, 2'd1, 24'h000200, 8'd1, 32'hC33C0000, 32'h02000200, 48);
        vecs[7] = mk(0, 2'd0, 24'h000200, 8'd1, 32'hC33C0000, 32'h03000200, 48);

        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", sel0, 1'b1);
        check("rst_sclk", sclk0, 1'b0);
        check("rst_dout", do0, 4'b0000);
        check("rst_oe", oe0, 4'b0001);
        check("rst_busy", busy0, 1'b0);
        check("rst_rdata", rdd0, 8'h00);
        check("rst_pulses", {rdv0, done0, wrr0}, 3'b000);
        check("rst_sel1", sel1, 1'b1);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

        // reset in the middle of a write header
        use1 = 1'b0;
        wb = 32'h55667788;
        snap();
        issue(2'd1, 24'h000300, 8'd3);
        cyc = 0;
        while (rise_tot - rise_base < 20 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midrst_timeout", (cyc < 4000), 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_sel", m_sel, 1'b1);
        check("midrst_sclk", m_sclk, 1'b0);
        check("midrst_busy", m_busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_nodone", done_tot - done_base, 0);
        run_vec("after_rst_wr", vecs[6], 1'b0);
        run_vec("after_rst_rd", vecs[7], 1'b0);

        run_vec("busy_start", vecs[0], 1'b1);

        // reserved op
        snap();
        issue(2'd3, 24'h000800, 8'd0);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (m_busy || !m_sel) bad++;
        end
        check("op3_idle", bad, 0);
        check("op3_done", done_tot - done_base, 0);

        // start in the done cycle
        use1 = 1'b0;
        snap();
        issue(2'd0, 24'h000800, 8'd0);
        cyc = 0;
        while (!m_done && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_timeout", (cyc < 4000), 1'b1);
        start = 1'b1; op = 2'd0; addr = 24'h000200; len = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        rd_base = rd_tot;
        done_base = done_tot;
        check("b2b_busy", m_busy, 1'b1);
        @(negedge clk); #1;
        check("b2b_gap", last_run, 2);
        wait_done("b2b", 1'b0, oe31, oe32);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_nrd", rd_tot - rd_base, 2);
        check("b2b_rd0", rd_got[rd_base % 64], 8'hC3);
        check("b2b_rd1", rd_got[(rd_base + 1) % 64], 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
